// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping datapath.
// Optional lap-hold display is enabled with STOPWATCH_LAP_EN.
package stopwatch_pkg;

  localparam int BCD_W = 4;
  localparam int DIV_DEFAULT = 1_000_000;
  localparam int CNT_W_DEFAULT = 20;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t LIM_9 = 4'd9;
  localparam bcd_t LIM_5 = 4'd5;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    bcd_t cs_tens;
    bcd_t cs_ones;
  } time_t;

  // {carry_out, next_digit}; out-of-range digits wrap to 0 and carry
  function automatic logic [BCD_W:0] bcd_inc(
    input bcd_t d,
    input bcd_t lim,
    input logic cin
  );
    if (!cin) return {1'b0, d};
    if (d >= lim) return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Centisecond prescaler: counts enabled cycles and emits a tick
// in the cycle where the count sits at DIV-1.
module stopwatch_tick_gen
  import stopwatch_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_tick = i_en && !i_clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// BCD stopwatch datapath: mm:ss.cc ripple chain driven by a prescaled tick.
// Define STOPWATCH_LAP_EN to add the i_lap port and lap-hold display.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  input  logic       i_stop,
  input  logic       i_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       i_lap,
`endif
  output logic [3:0] o_cs_ones,
  output logic [3:0] o_cs_tens,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_min_tens,
  output logic       o_rollover
);

  time_t time_q, time_d;
  time_t disp;
  logic  roll_q, roll_d;
  logic  tick;
  logic  c;
  logic  unused_stop;

  // run wins over stop, so the stop level carries no state
  assign unused_stop = i_stop;

  stopwatch_tick_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_en   (i_run),
    .i_clr  (i_clear),
    .o_tick (tick)
  );

  always_comb begin
    time_d = time_q;
    roll_d = 1'b0;
    c = 1'b0;
    if (i_clear) begin
      time_d = '0;
    end else if (tick) begin
      {c, time_d.cs_ones}  = bcd_inc(time_q.cs_ones, LIM_9, 1'b1);
      {c, time_d.cs_tens}  = bcd_inc(time_q.cs_tens, LIM_9, c);
      {c, time_d.sec_ones} = bcd_inc(time_q.sec_ones, LIM_9, c);
      {c, time_d.sec_tens} = bcd_inc(time_q.sec_tens, LIM_5, c);
      {c, time_d.min_ones} = bcd_inc(time_q.min_ones, LIM_9, c);
      {c, time_d.min_tens} = bcd_inc(time_q.min_tens, LIM_5, c);
      roll_d = c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_q <= '0;
      roll_q <= 1'b0;
    end else begin
      time_q <= time_d;
      roll_q <= roll_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  time_t lap_q, lap_d;
  logic  lap_act_q, lap_act_d;

  always_comb begin
    lap_d = lap_q;
    lap_act_d = lap_act_q;
    if (i_clear) begin
      lap_d = '0;
      lap_act_d = 1'b0;
    end else if (i_lap) begin
      if (!lap_act_q) begin
        lap_d = time_q;
        lap_act_d = 1'b1;
      end else begin
        lap_act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q <= '0;
      lap_act_q <= 1'b0;
    end else begin
      lap_q <= lap_d;
      lap_act_q <= lap_act_d;
    end
  end

  assign disp = lap_act_q ? lap_q : time_q;
`else
  assign disp = time_q;
`endif

  assign o_cs_ones  = disp.cs_ones;
  assign o_cs_tens  = disp.cs_tens;
  assign o_sec_ones = disp.sec_ones;
  assign o_sec_tens = disp.sec_tens;
  assign o_min_ones = disp.min_ones;
  assign o_min_tens = disp.min_tens;
  assign o_rollover = roll_q;

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Timekeeping datapath driven by the run/stop/clear control levels from the stopwatch control FSM. It consumes those levels and counts elapsed time in BCD: centiseconds, seconds and minutes. Its digit outputs feed the 7-segment display multiplexer. Wraps from 59:59.99 to 00:00.00.

Parameters:
DIV, 1_000_000, clk cycles per centisecond tick (100 MHz / 100 Hz); must be >= 2
CNT_W, 20, prescaler width; must satisfy 2**CNT_W >= DIV

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
i_run  input  1  level; count while high
i_stop  input  1  level; hold value while high (informational, no state change)
i_clear  input  1  level; force all counters to zero while high
o_cs_ones  output  4  centiseconds ones, BCD 0-9
o_cs_tens  output  4  centiseconds tens, BCD 0-9
o_sec_ones  output  4  seconds ones, BCD 0-9
o_sec_tens  output  4  seconds tens, BCD 0-5
o_min_ones  output  4  minutes ones, BCD 0-9
o_min_tens  output  4  minutes tens, BCD 0-5
o_rollover  output  1  one-cycle pulse on the 59:59.99 -> 00:00.00 wrap
i_lap  input  1  lap toggle pulse (present only with STOPWATCH_LAP_EN)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high: on a clk edge with reset=1, prescaler, all digits and o_rollover go to 0.
- Priority on each clk edge: reset > i_clear > i_run > hold.
- i_clear=1: prescaler and all six digits go to 0 on the next edge. o_rollover=0. i_run is ignored while i_clear is high.
- i_run=1, i_clear=0: the prescaler increments.
  - When the prescaler equals DIV-1, it returns to 0 and a tick is issued in the same cycle.
  - The digit chain advances on the edge that consumes the tick.
  - First increment occurs DIV edges after i_run rises from a cleared state.
- i_run=0, i_clear=0: prescaler and digits hold. Resuming continues from the held prescaler value, so no partial tick is lost.
- Digit chain on a tick: ripple-carry BCD.
  - cs_ones 9->0 carries into cs_tens.
  - cs_tens 9->0 carries into sec_ones.
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min_ones.
  - min_ones 9->0 carries into min_tens.
  - min_tens 5->0 is the overall wrap.
  - All carries resolve in the same edge; there is no multi-cycle ripple.
- o_rollover is registered. It is high for exactly the one cycle following the wrap edge.
- Digits are registered outputs with zero combinational path from inputs.
- Illegal BCD values cannot occur. If one is forced in simulation, the next tick loads that digit with 0 and carries.
- i_stop is not used for control; it is kept for interface symmetry with the control FSM. i_run=1 and i_stop=1 together is treated as run.

Optional Feature:
STOPWATCH_LAP_EN
- Defined: i_lap port and a 24-bit lap register plus a lap_active flag are added.
  - An i_lap pulse while lap_active=0 copies the live digits into the lap register and sets lap_active=1.
  - The next i_lap pulse clears lap_active.
  - While lap_active=1, the outputs show the lap register and counting continues internally.
  - i_clear or reset clears lap_active and the lap register.
- Not defined: no i_lap port, and the outputs always show the live digits.

Decomposition:
- Shared package stopwatch_pkg holds:
  - BCD digit width (4)
  - digit limits: 9, and 5 for the tens of seconds and minutes
  - default DIV
  - a packed 24-bit time typedef (6 digits, min_tens in the MSBs)
- One natural sub-module: stopwatch_tick_gen.
  - Prescaler with enable and clear, producing a one-cycle tick.
  - Parameterised by DIV and CNT_W.
- The BCD chain stays in the top module.

Test Plan:
- DIV=4; reset 2 cycles then i_run=1 for 40 cycles -> 10 ticks; digits read 00:00.10, i.e. cs_tens=1, cs_ones=0.
- DIV=4; run for 6 cycles, drop i_run for 20 cycles, then run 2 cycles -> exactly 2 ticks total; the held prescaler resumes and digits = 00:00.02.
- DIV=4; preload 59:59.98 via force, run 8 cycles -> 59:59.99 then 00:00.00; o_rollover high exactly 1 cycle after the wrap edge.
- DIV=4; i_run=1 and i_clear=1 together for 10 cycles -> all digits 0 and prescaler 0; release i_clear -> first tick 4 cycles later.
- Running at 00:00.37: assert reset for 1 cycle -> all outputs 0 on the next edge, o_rollover=0, no stray tick.
- STOPWATCH_LAP_EN defined: i_lap at 00:00.05, run 20 more cycles -> outputs stay 00:00.05; second i_lap -> outputs show live 00:00.10.
